dff_sipo_collector: RTL

- Downstream consumer of the D flip-flop stage's registered output q. Treats q as a serial bit stream.
- Qualified by a bit strobe, it assembles WIDTH consecutive bits into a parallel word.
- Presents each word on a one-entry valid/ready output register to the next stage.
- Flags a sticky overflow when a completed word cannot be accepted.

---
 rtl/dff_sipo_collector.sv | 84 ++++++++
 1 files changed

// File: rtl/dff_sipo_collector.sv
// rtl/dff_sipo_collector.sv - serial-to-parallel word collector with one-entry valid/ready output slot
module dff_sipo_collector #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overflow,
    input  logic                     clr_overflow
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             complete;
    logic             slot_free;

    always_comb begin
        shifted   = MSB_FIRST ? {sr_q[WIDTH-2:0], bit_in} : {bit_in, sr_q[WIDTH-1:1]};
        last_bit  = (cnt_q == CW'(WIDTH - 1));
        complete  = bit_valid && last_bit;
        slot_free = !valid_q || out_ready;

        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        // Stale bits left in sr after a wrap are pushed out by the next WIDTH shifts.
        if (bit_valid) begin
            sr_d  = shifted;
            cnt_d = last_bit ? '0 : cnt_q + CW'(1);
        end

        if (complete && slot_free) begin
            data_d  = shifted;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear must leave the flag set.
        if (clr_overflow) begin
            ovf_d = 1'b0;
        end
        if (complete && !slot_free) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign bit_cnt   = cnt_q;
    assign overflow  = ovf_q;
endmodule
